decode_stage_pipelined: RTL and testbench

Parametrised next-generation decode stage for the 16-bit pipelined processor. It holds a NUM_REGS x DATA_W register file, decodes the 5-bit opcode into control signals, and registers operands and controls into an ID/EX pipeline register with a valid bit. It also detects load-use hazards and stalls fetch, accepts a downstream hold and a branch flush, and takes the write-back port from the WB stage.

---
 rtl/decode_stage_pipelined_if.sv | 42 ++++
 rtl/decode_stage_pipelined.sv | 152 +++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipelined_if.sv
// Decode-stage bus: fetch instruction, flush/hold controls, WB write port and ID/EX outputs.
interface decode_stage_pipelined_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  in_valid;
  logic [15:0]           instruction;
  logic                  flush;
  logic                  ex_hold;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  if_stall;
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [3:0]            ex_alu_op;
  logic                  ex_wb;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_imm_sel;
  logic                  ex_push;
  logic                  ex_pop;
  logic [1:0]            ex_jump_type;
  logic                  ex_jump;

  modport master (
    output in_valid, instruction, flush, ex_hold, wb_en, wb_addr, wb_data,
    input  if_stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ex_alu_op,
           ex_wb, ex_mem_read, ex_mem_write, ex_imm_sel, ex_push, ex_pop,
           ex_jump_type, ex_jump
  );

  modport slave (
    input  in_valid, instruction, flush, ex_hold, wb_en, wb_addr, wb_data,
    output if_stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ex_alu_op,
           ex_wb, ex_mem_read, ex_mem_write, ex_imm_sel, ex_push, ex_pop,
           ex_jump_type, ex_jump
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file, opcode decode, load-use hazard detection and ID/EX register.
// Optional macro DECODE_BYPASS_EN: write-first bypass from the WB port to the operand reads.
module decode_stage_pipelined #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 8
) (
  input logic clk,
  input logic reset,
  decode_stage_pipelined_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] dst;
    logic [3:0]            alu_op;
    logic                  wb;
    logic                  mem_read;
    logic                  mem_write;
    logic                  imm_sel;
    logic                  push;
    logic                  pop;
    logic [1:0]            jump_type;
    logic                  jump;
  } idex_t;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  idex_t                 r_idex;
  idex_t                 w_dec;
  logic [4:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic                  w_reads_rs;
  logic                  w_reads_rt;
  logic                  w_hazard;
  logic [DATA_W-1:0]     w_rs_data;
  logic [DATA_W-1:0]     w_rt_data;

  assign w_opcode = bus.instruction[15:11];
  assign w_rs     = bus.instruction[8 +: REG_ADDR_W];
  assign w_rt     = bus.instruction[5 +: REG_ADDR_W];

  always_comb begin
    w_rs_data = r_regs[w_rs];
    w_rt_data = r_regs[w_rt];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == w_rs)) w_rs_data = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == w_rt)) w_rt_data = bus.wb_data;
`endif
  end

  always_comb begin
    w_dec         = '0;
    w_reads_rs    = 1'b0;
    w_reads_rt    = 1'b0;
    w_dec.valid   = 1'b1;
    w_dec.rs_data = w_rs_data;
    w_dec.rt_data = w_rt_data;
    w_dec.imm     = DATA_W'(bus.instruction[IMM_W-1:0]);
    w_dec.dst     = w_rs;
    casez (w_opcode)
      5'b00000: ;
      5'b00???: begin
        w_dec.alu_op = w_opcode[3:0];
        w_dec.wb     = 1'b1;
        w_reads_rs   = 1'b1;
        w_reads_rt   = 1'b1;
      end
      5'b01???: begin
        w_dec.alu_op = w_opcode[3:0];
        w_dec.wb     = 1'b1;
        w_reads_rs   = 1'b1;
      end
      5'b10000: begin
        w_dec.wb      = 1'b1;
        w_dec.imm_sel = 1'b1;
      end
      5'b10001: begin
        w_dec.mem_read = 1'b1;
        w_dec.wb       = 1'b1;
        w_reads_rs     = 1'b1;
      end
      5'b10010: begin
        w_dec.mem_write = 1'b1;
        w_reads_rs      = 1'b1;
        w_reads_rt      = 1'b1;
      end
      5'b10011: begin
        w_dec.mem_write = 1'b1;
        w_dec.push      = 1'b1;
        w_reads_rs      = 1'b1;
      end
      5'b10100: begin
        w_dec.mem_read = 1'b1;
        w_dec.pop      = 1'b1;
        w_dec.wb       = 1'b1;
      end
      5'b110??: begin
        w_dec.jump      = 1'b1;
        w_dec.jump_type = w_opcode[1:0];
        w_reads_rs      = 1'b1;
      end
      default: ;
    endcase
  end

  // Only registers the incoming instruction really reads can create a load-use hazard.
  assign w_hazard = bus.in_valid & r_idex.valid & r_idex.mem_read & r_idex.wb &
                    ((w_reads_rs & (r_idex.dst == w_rs)) |
                     (w_reads_rt & (r_idex.dst == w_rt)));

  assign bus.if_stall = ~reset & ~bus.flush & (bus.ex_hold | w_hazard);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_en) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_idex <= '0;
    end else if (bus.ex_hold) begin
      r_idex <= r_idex;
    end else if (w_hazard || !bus.in_valid) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_dec;
    end
  end

  assign bus.ex_valid     = r_idex.valid;
  assign bus.ex_rs_data   = r_idex.rs_data;
  assign bus.ex_rt_data   = r_idex.rt_data;
  assign bus.ex_imm       = r_idex.imm;
  assign bus.ex_dst       = r_idex.dst;
  assign bus.ex_alu_op    = r_idex.alu_op;
  assign bus.ex_wb        = r_idex.wb;
  assign bus.ex_mem_read  = r_idex.mem_read;
  assign bus.ex_mem_write = r_idex.mem_write;
  assign bus.ex_imm_sel   = r_idex.imm_sel;
  assign bus.ex_push      = r_idex.push;
  assign bus.ex_pop       = r_idex.pop;
  assign bus.ex_jump_type = r_idex.jump_type;
  assign bus.ex_jump      = r_idex.jump;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed self-checking bench for decode_stage_pipelined.
module tb_decode_stage_pipelined;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  decode_stage_pipelined_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

  decode_stage_pipelined #(.DATA_W(16), .REG_ADDR_W(3), .IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [7:0] imm);
    ins = {op, rs, 8'h00};
    ins[7:5] = rt;
    if (imm != 8'h00) ins[7:0] = imm;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b1; bus.instruction = ins(5'b00001, 3'd1, 3'd2, 8'h00);
    bus.flush = 1'b0; bus.ex_hold = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    tick(); tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_wb, bus.ex_alu_op, bus.ex_dst, bus.ex_rs_data} !== 25'd0) begin
      n_err++; $display("FAIL reset_ex: got valid=%b wb=%b alu=%h dst=%h rs=%h, expected all 0",
                        bus.ex_valid, bus.ex_wb, bus.ex_alu_op, bus.ex_dst, bus.ex_rs_data);
    end
    n_vec++;
    if (bus.if_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b expected 0", bus.if_stall);
    end
    reset = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic test_alu();
    wr(3'd1, 16'h0005); wr(3'd2, 16'h0003); wr(3'd4, 16'h0044); wr(3'd5, 16'h0055);
    bus.in_valid = 1'b1; bus.instruction = ins(5'b00001, 3'd1, 3'd2, 8'h00);
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data, bus.ex_alu_op, bus.ex_wb, bus.ex_dst}
        !== {1'b1, 16'h0005, 16'h0003, 4'b0001, 1'b1, 3'd1}) begin
      n_err++; $display("FAIL alu: got v=%b rs=%h rt=%h op=%h wb=%b dst=%h, expected 1 0005 0003 1 1 1",
                        bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data, bus.ex_alu_op, bus.ex_wb, bus.ex_dst);
    end
  endtask

  task automatic test_load_use();
    bus.instruction = ins(5'b10001, 3'd3, 3'd0, 8'h00);
    tick();
    bus.instruction = ins(5'b00001, 3'd3, 3'd2, 8'h00);
    #1;
    n_vec++;
    if (bus.if_stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall: got %b expected 1", bus.if_stall);
    end
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_wb, bus.ex_mem_read, bus.if_stall} !== 4'b0000) begin
      n_err++; $display("FAIL lu_bubble: got v/wb/mr/stall=%b%b%b%b expected 0000",
                        bus.ex_valid, bus.ex_wb, bus.ex_mem_read, bus.if_stall);
    end
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_alu_op, bus.ex_dst, bus.ex_rt_data} !== {1'b1, 4'b0001, 3'd3, 16'h0003}) begin
      n_err++; $display("FAIL lu_after: got v=%b op=%h dst=%h rt=%h expected 1 1 3 0003",
                        bus.ex_valid, bus.ex_alu_op, bus.ex_dst, bus.ex_rt_data);
    end
    // independent registers: no stall
    bus.instruction = ins(5'b10001, 3'd3, 3'd0, 8'h00);
    tick();
    bus.instruction = ins(5'b00001, 3'd4, 3'd5, 8'h00);
    #1;
    n_vec++;
    if (bus.if_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_nostall: got %b expected 0", bus.if_stall);
    end
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data} !== {1'b1, 16'h0044, 16'h0055}) begin
      n_err++; $display("FAIL lu_noload: got v=%b rs=%h rt=%h expected 1 0044 0055",
                        bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data);
    end
    // one-operand op whose rt field matches the load dst is not a hazard
    bus.instruction = ins(5'b10001, 3'd3, 3'd0, 8'h00);
    tick();
    bus.instruction = ins(5'b01000, 3'd4, 3'd3, 8'h00);
    #1;
    n_vec++;
    if (bus.if_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_rtunused: got %b expected 0", bus.if_stall);
    end
    tick();
  endtask

  task automatic test_flush_hold();
    bus.instruction = ins(5'b10011, 3'd1, 3'd0, 8'h00);
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_push, bus.ex_mem_write} !== 3'b111) begin
      n_err++; $display("FAIL push_load: got v/push/mw=%b%b%b expected 111",
                        bus.ex_valid, bus.ex_push, bus.ex_mem_write);
    end
    bus.flush = 1'b1; bus.ex_hold = 1'b1;
    #1;
    n_vec++;
    if (bus.if_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: got %b expected 0", bus.if_stall);
    end
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_push, bus.ex_mem_write} !== 3'b000) begin
      n_err++; $display("FAIL flush: got v/push/mw=%b%b%b expected 000",
                        bus.ex_valid, bus.ex_push, bus.ex_mem_write);
    end
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
    bus.instruction = ins(5'b00010, 3'd4, 3'd5, 8'h00);
    tick();
    bus.ex_hold = 1'b1; bus.instruction = ins(5'b01000, 3'd1, 3'd0, 8'h00);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 16'h0099;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_en = 1'b0;
      n_vec++;
      if ({bus.ex_valid, bus.ex_alu_op, bus.ex_rs_data, bus.ex_rt_data, bus.if_stall}
          !== {1'b1, 4'b0010, 16'h0044, 16'h0055, 1'b1}) begin
        n_err++; $display("FAIL hold%0d: got v=%b op=%h rs=%h rt=%h stall=%b expected 1 2 0044 0055 1",
                          i, bus.ex_valid, bus.ex_alu_op, bus.ex_rs_data, bus.ex_rt_data, bus.if_stall);
      end
    end
    bus.ex_hold = 1'b0;
    tick();
    n_vec++;
    if ({bus.ex_alu_op, bus.ex_rs_data, bus.ex_wb} !== {4'b1000, 16'h0005, 1'b1}) begin
      n_err++; $display("FAIL hold_release: got op=%h rs=%h wb=%b expected 8 0005 1",
                        bus.ex_alu_op, bus.ex_rs_data, bus.ex_wb);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_rt;
`ifdef DECODE_BYPASS_EN
    exp_rt = 16'hBEEF;
`else
    exp_rt = 16'h0003;
`endif
    bus.instruction = ins(5'b10010, 3'd1, 3'd2, 8'h00);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'hBEEF;
    tick();
    bus.wb_en = 1'b0;
    n_vec++;
    if ({bus.ex_rt_data, bus.ex_mem_write, bus.ex_wb} !== {exp_rt, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL bypass: got rt=%h mw=%b wb=%b expected %h 1 0",
                        bus.ex_rt_data, bus.ex_mem_write, bus.ex_wb, exp_rt);
    end
    tick();
    n_vec++;
    if (bus.ex_rt_data !== 16'hBEEF) begin
      n_err++; $display("FAIL wb_written: got %h expected beef", bus.ex_rt_data);
    end
  endtask

  task automatic test_jump_ldm();
    bus.instruction = ins(5'b11010, 3'd1, 3'd0, 8'h00);
    tick();
    n_vec++;
    if ({bus.ex_jump, bus.ex_jump_type, bus.ex_wb, bus.ex_mem_read} !== 5'b11000) begin
      n_err++; $display("FAIL jump: got j=%b jt=%b wb=%b mr=%b expected 1 10 0 0",
                        bus.ex_jump, bus.ex_jump_type, bus.ex_wb, bus.ex_mem_read);
    end
    bus.instruction = ins(5'b10000, 3'd6, 3'd0, 8'hA7);
    tick();
    n_vec++;
    if ({bus.ex_imm, bus.ex_imm_sel, bus.ex_wb, bus.ex_dst, bus.ex_jump} !== {16'h00A7, 1'b1, 1'b1, 3'd6, 1'b0}) begin
      n_err++; $display("FAIL ldm: got imm=%h isel=%b wb=%b dst=%h j=%b expected 00a7 1 1 6 0",
                        bus.ex_imm, bus.ex_imm_sel, bus.ex_wb, bus.ex_dst, bus.ex_jump);
    end
    bus.instruction = ins(5'b10100, 3'd2, 3'd0, 8'h00);
    tick();
    n_vec++;
    if ({bus.ex_pop, bus.ex_mem_read, bus.ex_wb, bus.ex_mem_write} !== 4'b1110) begin
      n_err++; $display("FAIL pop: got pop/mr/wb/mw=%b%b%b%b expected 1110",
                        bus.ex_pop, bus.ex_mem_read, bus.ex_wb, bus.ex_mem_write);
    end
  endtask

  task automatic test_reset_mid_hold();
    bus.ex_hold = 1'b1; reset = 1'b1;
    #1;
    n_vec++;
    if (bus.if_stall !== 1'b0) begin
      n_err++; $display("FAIL rst_hold_stall: got %b expected 0", bus.if_stall);
    end
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_pop, bus.ex_wb} !== 3'b000) begin
      n_err++; $display("FAIL rst_hold: got v/pop/wb=%b%b%b expected 000",
                        bus.ex_valid, bus.ex_pop, bus.ex_wb);
    end
    reset = 1'b0; bus.ex_hold = 1'b0;
    bus.instruction = ins(5'b00001, 3'd1, 3'd2, 8'h00);
    tick();
    n_vec++;
    if ({bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data} !== {1'b1, 16'h0000, 16'h0000}) begin
      n_err++; $display("FAIL rst_regs: got v=%b rs=%h rt=%h expected 1 0000 0000",
                        bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_flush_hold();
    test_bypass();
    test_jump_ldm();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
